// File: rtl/mux16_arb_pkg.sv
// Shared constants for the 16-way mux arbiter: requester count, select width,
// FSM state encoding and a one-hot decode helper.
package mux16_arb_pkg;

   localparam int NREQ  = 16;
   localparam int SEL_W = 4;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] i);
      return {{(NREQ-1){1'b0}}, 1'b1} << i;
   endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotating-priority picker: first set bit of req & mask,
// searching upward from ptr+1 (or from 0 when fixed), wrapping at 15.
module rr_pick16
   import mux16_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  mask,
   input  logic [SEL_W-1:0] ptr,
   input  logic             fixed,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [NREQ-1:0]  cand;
   logic [SEL_W-1:0] start;
   logic [SEL_W-1:0] pos;

   assign cand  = req & mask;
   assign start = fixed ? '0 : ptr + 1'b1;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos = start + SEL_W'(k);
         if (cand[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin (or fixed-priority) arbiter driving a shared 16:1 word mux with a
// valid/ready output and one-hot ack. Optional burst lock: MUX16_ARB_LOCK_EN.
module mux16_rr_arbiter
   import mux16_arb_pkg::*;
#(
   parameter int PRIO_FIXED = 0,
   parameter int NREQ       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            out_ready,
`ifdef MUX16_ARB_LOCK_EN
   input  logic [NREQ-1:0] lock,
`endif
   output logic            mux_e,
   output logic [3:0]      mux_s,
   output logic            out_valid,
   output logic [NREQ-1:0] ack,
   output logic            busy
);

   if (NREQ != 16) begin : g_nreq_check
      $error("mux16_rr_arbiter: NREQ must be 16 to match the 4-bit mux select");
   end

   logic [0:0]       state_q, state_d;
   logic             mux_e_q, mux_e_d;
   logic [SEL_W-1:0] mux_s_q, mux_s_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             xfer, keep, found, fixed;
   logic [SEL_W-1:0] idx, pick_ptr;
   logic [NREQ-1:0]  sel_oh, pick_mask;

   assign sel_oh    = onehot16(mux_s_q);
   assign busy      = (state_q == GRANT);
   assign out_valid = busy & req[mux_s_q];
   assign xfer      = out_valid & out_ready;
   assign ack       = xfer ? sel_oh : '0;
   assign mux_e     = mux_e_q;
   assign mux_s     = mux_s_q;
   assign fixed     = (PRIO_FIXED != 0);

`ifdef MUX16_ARB_LOCK_EN
   assign keep = xfer & lock[mux_s_q];
`else
   assign keep = 1'b0;
`endif

   // On a transfer the served line is still requesting: rotate past it in RR
   // mode; in fixed mode it may win again, which the FSM turns into a bubble.
   assign pick_ptr  = xfer ? mux_s_q : ptr_q;
   assign pick_mask = (xfer && !fixed) ? ~sel_oh : '1;

   rr_pick16 u_pick (
      .req   (req),
      .mask  (pick_mask),
      .ptr   (pick_ptr),
      .fixed (fixed),
      .found (found),
      .idx   (idx)
   );

   always_comb begin
      state_d = state_q;
      mux_e_d = mux_e_q;
      mux_s_d = mux_s_q;
      ptr_d   = ptr_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = GRANT;
            mux_e_d = 1'b1;
            mux_s_d = idx;
         end else begin
            mux_e_d = 1'b0;
         end
      end else if (xfer) begin
         if (!keep) begin
            ptr_d = mux_s_q;
            if (found && idx != mux_s_q) begin
               mux_s_d = idx;
            end else begin
               state_d = IDLE;
               mux_e_d = 1'b0;
            end
         end
      end else if (!req[mux_s_q]) begin
         state_d = IDLE;
         mux_e_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mux_e_q <= 1'b0;
         mux_s_q <= '0;
         ptr_q   <= 4'd15;
      end else begin
         state_q <= state_d;
         mux_e_q <= mux_e_d;
         mux_s_q <= mux_s_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: one round-robin and one fixed-priority instance
// on shared stimulus, each checked against a per-cycle behavioural model.
module tb_mux16_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic        out_ready = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
   logic [15:0] lock = '0;
`endif

   logic [1:0]       mux_e_w, out_valid_w, busy_w;
   logic [1:0][3:0]  mux_s_w;
   logic [1:0][15:0] ack_w;

   int n_tests = 0;
   int n_fail  = 0;

   // model: granted requester (-1 = idle), current select, last served
   int m_hold[2] = '{-1, -1};
   int m_sel[2]  = '{0, 0};
   int m_last[2] = '{15, 15};

   always #5 clk = ~clk;

   mux16_rr_arbiter #(.PRIO_FIXED(0)) u_rr (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
`ifdef MUX16_ARB_LOCK_EN
      .lock(lock),
`endif
      .mux_e(mux_e_w[0]), .mux_s(mux_s_w[0]), .out_valid(out_valid_w[0]),
      .ack(ack_w[0]), .busy(busy_w[0])
   );

   mux16_rr_arbiter #(.PRIO_FIXED(1)) u_fx (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
`ifdef MUX16_ARB_LOCK_EN
      .lock(lock),
`endif
      .mux_e(mux_e_w[1]), .mux_s(mux_s_w[1]), .out_valid(out_valid_w[1]),
      .ack(ack_w[1]), .busy(busy_w[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // next requester strictly after 'from' in circular order, never 'skip'
   function automatic int rr_next(input logic [15:0] r, input int from, input int skip);
      for (int k = 1; k <= 16; k++) begin
         int i;
         i = (from + k) % 16;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   function automatic int lowest(input logic [15:0] r);
      for (int i = 0; i < 16; i++) if (r[i]) return i;
      return -1;
   endfunction

   // Drive one cycle's inputs, compare both DUTs against the model, then
   // advance the model across the coming rising edge.
   task automatic step(input logic [15:0] r, input logic rdy, input logic rs);
      @(negedge clk);
      req = r; out_ready = rdy; rst = rs;
      #1;
      for (int d = 0; d < 2; d++) begin
         string nm;
         int h, w;
         logic ev, lk;
         logic [15:0] ea;
         nm = (d == 0) ? "rr" : "fx";
         h  = m_hold[d];
         ev = (h >= 0) && r[h];
         ea = (ev && rdy) ? (16'd1 << h) : 16'd0;
         check({nm, ".mux_e"}, 32'(mux_e_w[d]), 32'(h >= 0));
         check({nm, ".mux_s"}, 32'(mux_s_w[d]), 32'(m_sel[d]));
         check({nm, ".out_valid"}, 32'(out_valid_w[d]), 32'(ev));
         check({nm, ".ack"}, 32'(ack_w[d]), 32'(ea));
         check({nm, ".busy"}, 32'(busy_w[d]), 32'(h >= 0));
         lk = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
         if (h >= 0) lk = lock[h];
`endif
         if (rs) begin
            m_hold[d] = -1; m_sel[d] = 0; m_last[d] = 15;
         end else if (h < 0) begin
            w = (d == 1) ? lowest(r) : rr_next(r, m_last[d], -1);
            if (w >= 0) begin m_hold[d] = w; m_sel[d] = w; end
         end else if (ev && rdy) begin
            if (!lk) begin
               m_last[d] = h;
               w = (d == 1) ? lowest(r) : rr_next(r, h, h);
               if (w == h) w = -1;
               m_hold[d] = w;
               if (w >= 0) m_sel[d] = w;
            end
         end else if (!ev) begin
            m_hold[d] = -1;
         end
      end
   endtask

   task automatic do_reset();
`ifdef MUX16_ARB_LOCK_EN
      lock = '0;
`endif
      step(16'h0, 1'b0, 1'b1);
      step(16'h0, 1'b0, 1'b1);
   endtask

   initial begin
      do_reset();

      // sole requester: grant, ack, one idle cycle
      step(16'h0001, 1'b1, 1'b0);
      check("d1.idle_first", 32'(mux_e_w[0]), 32'd0);
      step(16'h0001, 1'b1, 1'b0);
      check("d1.mux_s", 32'(mux_s_w[0]), 32'd0);
      check("d1.ack", 32'(ack_w[0]), 32'h0001);
      step(16'h0001, 1'b1, 1'b0);
      check("d1.idle_after", 32'(mux_e_w[0]), 32'd0);

      // all requesting: 0..15 then wrap, zero bubble
      do_reset();
      step(16'hFFFF, 1'b1, 1'b0);
      for (int i = 0; i <= 16; i++) begin
         step(16'hFFFF, 1'b1, 1'b0);
         check("d2.seq", 32'(mux_s_w[0]), 32'(i % 16));
         check("d2.ack", 32'(ack_w[0]), 32'(16'd1 << (i % 16)));
      end

      // stall holds the grant, release hands over to 5
      do_reset();
      step(16'h0030, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(16'h0030, 1'b0, 1'b0);
         check("d3.stall_sel", 32'(mux_s_w[0]), 32'd4);
         check("d3.stall_ack", 32'(ack_w[0]), 32'd0);
      end
      step(16'h0030, 1'b1, 1'b0);
      check("d3.ack", 32'(ack_w[0]), 32'h0010);
      step(16'h0030, 1'b1, 1'b0);
      check("d3.next", 32'(mux_s_w[0]), 32'd5);

      // abort: requester 7 withdraws, then 9 is granted from the old pointer
      do_reset();
      step(16'h0080, 1'b0, 1'b0);
      step(16'h0080, 1'b0, 1'b0);
      check("d4.grant7", 32'(mux_s_w[0]), 32'd7);
      step(16'h0000, 1'b0, 1'b0);
      check("d4.abort_valid", 32'(out_valid_w[0]), 32'd0);
      step(16'h0200, 1'b1, 1'b0);
      check("d4.idle", 32'(busy_w[0]), 32'd0);
      step(16'h0200, 1'b1, 1'b0);
      check("d4.grant9", 32'(ack_w[0]), 32'h0200);

      // fixed priority: 1 always wins, 15 starves
      do_reset();
      step(16'h8002, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(16'h8002, 1'b1, 1'b0);
         check("d5.fixed_ack", 32'(ack_w[1]), (i % 2 == 0) ? 32'h0002 : 32'h0);
      end

`ifdef MUX16_ARB_LOCK_EN
      // locked burst on 2 for three acks, then hand over to 8
      do_reset();
      lock = 16'h0004;
      step(16'h0104, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) lock = 16'h0;
         step(16'h0104, 1'b1, 1'b0);
         check("d6.lock_ack", 32'(ack_w[0]), 32'h0004);
      end
      step(16'h0104, 1'b1, 1'b0);
      check("d6.after_lock", 32'(mux_s_w[0]), 32'd8);
`endif

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] r;
         logic rdy, rs;
         case ($urandom_range(0, 3))
            0: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            1: r = 16'($urandom) | 16'($urandom);
            2: r = 16'd1 << $urandom_range(0, 15);
            default: r = 16'($urandom);
         endcase
         rdy = ($urandom_range(0, 9) < 7);
         rs  = ($urandom_range(0, 299) == 0);
         if (rs) rdy = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
         lock = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
`endif
         step(r, rdy, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
